// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter.
// Grant codes: bit 0 = requester A, bit 1 = requester B.
package regfile_pkg;

    localparam int REG_ADDR_W     = 4;
    localparam int NUM_REGS       = 16;
    localparam int DATA_W_DEFAULT = 32;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_A    = 2'b01;
    localparam logic [1:0] GNT_B    = 2'b10;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with a hold input.
// Ports: i_clock, i_reset (async high), i_hold, i_req[1:0] (0=A,1=B) -> o_gnt[1:0].
module rr_arbiter_2
    import regfile_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_hold,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    last_e      r_last;
    logic [1:0] w_gnt;

    // Tie goes to whoever did not win last; reset leaves B as last winner
    // so A takes the first tie.
    always_comb begin
        w_gnt = GNT_NONE;
        if (!i_hold) begin
            unique case (i_req)
                2'b01:   w_gnt = GNT_A;
                2'b10:   w_gnt = GNT_B;
                2'b11:   w_gnt = (r_last == LAST_B) ? GNT_A : GNT_B;
                default: w_gnt = GNT_NONE;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_last <= LAST_B;
        end else if (w_gnt == GNT_A) begin
            r_last <= LAST_A;
        end else if (w_gnt == GNT_B) begin
            r_last <= LAST_B;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU writeback (A) and load
// return (B); registered write stage plus read-after-write hazard flags.
// Ports: clock, reset (async high), hold; a_/b_ valid/addr/data/ready;
//        rd_addr1/2 in; wr_data/wr_sel/wr_en (registered); hazard1/2 (comb).
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int W = DATA_W_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [W-1:0]          a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [W-1:0]          b_data,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] rd_addr1,
    input  logic [REG_ADDR_W-1:0] rd_addr2,
    output logic [W-1:0]          wr_data,
    output logic [REG_ADDR_W-1:0] wr_sel,
    output logic                  wr_en,
    output logic                  hazard1,
    output logic                  hazard2
);

    logic [1:0]            w_gnt;
    logic [W-1:0]          w_data;
    logic [REG_ADDR_W-1:0] w_addr;

    logic [W-1:0]          r_wr_data;
    logic [REG_ADDR_W-1:0] r_wr_sel;
    logic                  r_wr_en;

    rr_arbiter_2 u_arb (
        .i_clock (clock),
        .i_reset (reset),
        .i_hold  (hold),
        .i_req   ({b_valid, a_valid}),
        .o_gnt   (w_gnt)
    );

    always_comb begin
        w_data = a_data;
        w_addr = a_addr;
        if (w_gnt == GNT_B) begin
            w_data = b_data;
            w_addr = b_addr;
        end
    end

    // Data/select hold their last value when idle; only wr_en drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_sel  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= (w_gnt != GNT_NONE);
            if (w_gnt != GNT_NONE) begin
                r_wr_sel  <= w_addr;
                r_wr_data <= w_data;
            end
        end
    end

    assign a_ready = w_gnt[0];
    assign b_ready = w_gnt[1];

    assign wr_data = r_wr_data;
    assign wr_sel  = r_wr_sel;
    assign wr_en   = r_wr_en;

    // Same-cycle read of wr_sel sees the old value; consumer stalls or
    // forwards wr_data.
    assign hazard1 = r_wr_en && (r_wr_sel == rd_addr1);
    assign hazard2 = r_wr_en && (r_wr_sel == rd_addr2);

endmodule
